// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-atomic round-robin arbiter sharing one UART TX byte stream
// between two frame sources, with a mid-frame stall watchdog.
module uart_tx_arb #(
    parameter int FRAME_LEN = 6,
    parameter int TIMEOUT   = 1024,
    parameter int TO_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       abort_err,
    output logic       abort_pulse,
    input  logic       err_clr
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_t;
    state_t state, state_n;
    logic ptr, ptr_n;
    logic [3:0] cnt, cnt_n;
    logic [TO_W-1:0] wd, wd_n;
    logic v, xfer, done, fire;
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        wd_n    = wd;
        done    = 1'b0;
        fire    = 1'b0;
        v       = state == G0 ? s0_valid : state == G1 ? s1_valid : 1'b0;
        xfer    = v && tx_ready;
        if (state == IDLE) begin
            cnt_n = '0;
            wd_n  = '0;
            if (s0_valid && (!s1_valid || !ptr))
                state_n = G0;
            else if (s1_valid)
                state_n = G1;
        end else begin
            cnt_n = cnt + 4'(xfer);
            wd_n  = v ? '0 : wd + TO_W'(1);
            done  = xfer && cnt == 4'(FRAME_LEN - 1);
            // frame end takes priority over a watchdog abort in the same cycle
            fire  = !done && !v && TIMEOUT != 0 && wd == TO_W'(TIMEOUT - 1);
            if (done || fire) begin
                state_n = IDLE;
                ptr_n   = state == G0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            wd          <= '0;
            abort_err   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            wd          <= wd_n;
            abort_pulse <= fire;
            abort_err   <= fire || (abort_err && !err_clr);
        end
    end
    assign grant    = {state == G1, state == G0};
    assign tx_valid = v;
    assign tx_data  = state == G0 ? s0_data : state == G1 ? s1_data : 8'h00;
    assign s0_ready = state == G0 && tx_ready;
    assign s1_ready = state == G1 && tx_ready;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a
// behavioural owner/byte-count/stall-count model of the arbitration rules.
module tb_uart_tx_arb;
    localparam int FL = 6;
    localparam int TO = 8;

    logic clk = 0, rst_n = 0;
    logic s0_valid = 0, s1_valid = 0, tx_ready = 0, err_clr = 0;
    logic [7:0] s0_data = 0, s1_data = 0;
    logic s0_ready, s1_ready, tx_valid, abort_err, abort_pulse;
    logic [7:0] tx_data;
    logic [1:0] grant;

    uart_tx_arb #(.FRAME_LEN(FL), .TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .abort_err(abort_err), .abort_pulse(abort_pulse),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] q0[$], q1[$];

    // model: owner 0 idle, 1 = s0, 2 = s1; stall counts consecutive valid-low grant cycles
    int m_own = 0, m_ptr = 0, m_cnt = 0, m_stall = 0;
    bit m_err = 0, m_pulse = 0;
    bit e_txv, e_r0, e_r1;
    logic [7:0] e_txd;
    logic [1:0] e_gnt;

    task automatic model_out();
        e_gnt = m_own == 1 ? 2'b01 : m_own == 2 ? 2'b10 : 2'b00;
        e_txv = m_own == 1 ? s0_valid : m_own == 2 ? s1_valid : 1'b0;
        e_txd = m_own == 1 ? s0_data : m_own == 2 ? s1_data : 8'h00;
        e_r0  = m_own == 1 && tx_ready;
        e_r1  = m_own == 2 && tx_ready;
    endtask

    task automatic model_edge();
        bit v, done, fire;
        if (!rst_n) begin
            m_own = 0; m_ptr = 0; m_cnt = 0; m_stall = 0; m_err = 0; m_pulse = 0;
        end else begin
            done = 0;
            fire = 0;
            if (m_own == 0) begin
                m_cnt = 0;
                m_stall = 0;
                if (s0_valid && (!s1_valid || m_ptr == 0)) m_own = 1;
                else if (s1_valid) m_own = 2;
            end else begin
                v = m_own == 1 ? s0_valid : s1_valid;
                if (v && tx_ready) m_cnt++;
                m_stall = v ? 0 : m_stall + 1;
                done = v && tx_ready && m_cnt == FL;
                fire = !done && TO != 0 && m_stall == TO;
                if (done || fire) begin
                    m_ptr = m_own == 1 ? 1 : 0;
                    m_own = 0;
                end
            end
            m_pulse = fire;
            m_err = fire || (m_err && !err_clr);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {tx_valid, tx_data, s0_ready, s1_ready, grant, abort_err, abort_pulse};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {e_txv, e_txd, e_r0, e_r1, e_gnt, m_err, m_pulse};
    endfunction

    task automatic drive(input bit g0, input bit g1, input bit txr, input bit clr);
        s0_valid = g0 && q0.size() > 0;
        s0_data  = s0_valid ? q0[0] : 8'h00;
        s1_valid = g1 && q1.size() > 0;
        s1_data  = s1_valid ? q1[0] : 8'h00;
        tx_ready = txr;
        err_clr  = clr;
    endtask

    task automatic settle();
        @(negedge clk);
        model_out();
    endtask

    task automatic advance();
        if (s0_valid && e_r0 && q0.size() > 0) void'(q0.pop_front());
        if (s1_valid && e_r1 && q1.size() > 0) void'(q1.pop_front());
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0;
        q0.delete();
        q1.delete();
        drive(0, 0, 0, 0);
        settle(); advance();
        settle(); advance();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 1, 1);
        s0_valid = 1; s1_valid = 1; s0_data = 8'hA5; s1_data = 8'h3C;
        settle(); advance();
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (dut_vec() !== 15'h0) begin
                errors++;
                $display("FAIL test_reset outputs: got %h exp %h", dut_vec(), 15'h0);
            end
            advance();
        end
        rst_n = 1;
    endtask

    task automatic test_single();
        logic [47:0] got = '0;
        int n = 0, gcnt = 0;
        bit s1r = 0;
        do_reset();
        q0 = '{8'h5A, 8'h00, 8'h01, 8'h15, 8'h00, 8'h4E};
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_single cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (tx_valid && s0_ready) begin got = {got[39:0], tx_data}; n++; end
            if (grant == 2'b01) gcnt++;
            s1r |= s1_ready;
            advance();
        end
        checks++;
        if (got !== 48'h5A0001_15004E || n != 6) begin
            errors++;
            $display("FAIL test_single bytes: got %h (%0d) exp 5a000115004e (6)", got, n);
        end
        checks++;
        if (gcnt != 6 || s1r) begin
            errors++;
            $display("FAIL test_single grant: got %0d cycles s1_ready=%0d exp 6 cycles s1_ready=0", gcnt, s1r);
        end
    endtask

    task automatic test_alternate();
        logic [9:0] owners = '0;
        logic [1:0] prev = 2'b00;
        bit adj = 0;
        do_reset();
        for (int k = 0; k < 3 * FL; k++) q0.push_back(8'($urandom));
        for (int k = 0; k < 2 * FL; k++) q1.push_back(8'($urandom));
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 1, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_alternate cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (prev == 2'b00 && grant != 2'b00) owners = {owners[7:0], grant};
            if (prev != 2'b00 && grant != 2'b00 && grant != prev) adj = 1;
            prev = grant;
            advance();
        end
        checks++;
        if (owners !== 10'b01_10_01_10_01 || adj) begin
            errors++;
            $display("FAIL test_alternate order: got %b gapless=%0d exp 0110011001 gapless=0", owners, adj);
        end
    endtask

    task automatic test_back_pressure();
        bit pat[4] = '{1, 0, 0, 1};
        logic [47:0] exp_w = '0, got = '0;
        bit ab = 0;
        do_reset();
        for (int k = 0; k < FL; k++) begin
            q1.push_back(8'($urandom));
            exp_w = {exp_w[39:0], q1[k]};
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 20) for (int k = 0; k < FL; k++) q1.push_back(8'($urandom));
            drive(0, 1, i < 20 ? pat[i % 4] : i > 33, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_back_pressure cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (i < 20 && tx_valid && s1_ready) got = {got[39:0], tx_data};
            ab |= abort_pulse;
            advance();
        end
        checks++;
        if (got !== exp_w || ab) begin
            errors++;
            $display("FAIL test_back_pressure bytes: got %h abort=%0d exp %h abort=0", got, ab, exp_w);
        end
    endtask

    task automatic test_abort();
        int l = -100, p = -1;
        logic [1:0] g_after = 2'b00;
        do_reset();
        for (int k = 0; k < 3; k++) q0.push_back(8'($urandom));
        for (int k = 0; k < FL; k++) q1.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            drive(1, i >= 2, 1, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_abort cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (s0_valid && e_gnt == 2'b01) l = cyc;
            if (p >= 0 && cyc == p + 1) g_after = grant;
            if (abort_pulse && p < 0) p = cyc;
            advance();
        end
        checks++;
        if (p - l != TO + 1) begin
            errors++;
            $display("FAIL test_abort timing: got pulse %0d cycles after last valid exp %0d", p - l, TO + 1);
        end
        checks++;
        if (abort_err !== 1'b1 || g_after !== 2'b10) begin
            errors++;
            $display("FAIL test_abort after: got err=%0d grant=%b exp err=1 grant=10", abort_err, g_after);
        end
    endtask

    task automatic test_err_clr();
        int l = -100, p = -1;
        drive(0, 0, 1, 1);
        settle(); advance();
        drive(0, 0, 1, 0);
        settle();
        checks++;
        if (abort_err !== 1'b0) begin
            errors++;
            $display("FAIL test_err_clr clear: got %0d exp 0", abort_err);
        end
        advance();
        for (int k = 0; k < 2; k++) q1.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, cyc == l + TO);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_err_clr cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (s1_valid && e_gnt == 2'b10) l = cyc;
            if (abort_pulse && p < 0) p = cyc;
            advance();
        end
        checks++;
        if (abort_err !== 1'b1 || p < 0) begin
            errors++;
            $display("FAIL test_err_clr set_wins: got err=%0d pulse_seen=%0d exp err=1 pulse_seen=1", abort_err, p >= 0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        for (int k = 0; k < FL; k++) q1.push_back(8'($urandom));
        for (int i = 0; i < 10 && n < 2; i++) begin
            drive(0, 1, 1, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_reset_mid cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (s1_valid && e_r1) n++;
            advance();
        end
        rst_n = 0;
        drive(0, 1, 1, 0);
        settle(); advance();
        rst_n = 1;
        for (int k = 0; k < FL; k++) q0.push_back(8'($urandom));
        drive(1, 1, 1, 0);
        settle();
        checks++;
        if (grant !== 2'b00 || tx_valid !== 1'b0 || n != 2) begin
            errors++;
            $display("FAIL test_reset_mid drop: got grant=%b tx_valid=%0d bytes=%0d exp 00 0 2", grant, tx_valid, n);
        end
        advance();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_reset_mid post cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (i == 0 && grant !== 2'b01) begin
                errors++;
                $display("FAIL test_reset_mid favour: got grant=%b exp 01", grant);
            end
            advance();
        end
    endtask

    task automatic test_random();
        int st0 = 0, st1 = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 9) == 0)
                for (int k = 0; k < FL; k++) q0.push_back(8'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 9) == 0)
                for (int k = 0; k < FL; k++) q1.push_back(8'($urandom));
            if (st0 > 0) st0--; else if ($urandom_range(0, 99) < 3) st0 = $urandom_range(1, 12);
            if (st1 > 0) st1--; else if ($urandom_range(0, 99) < 3) st1 = $urandom_range(1, 12);
            drive(st0 == 0, st1 == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            settle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL test_random cyc %0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_back_pressure();
        test_abort();
        test_err_clr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
